// File: rtl/sdram_bram_responder.sv
// Target-side SDR SDRAM emulator answering from block RAM (16-bit, 4 banks, BL=1, CL 2/3).
// Optional macro SDRAM_TIMING_CHECK_EN adds tRCD/tRP/tRFC violation checks.
module sdram_bram_responder #(
  parameter int unsigned MEM_AW = 14,
  parameter int unsigned TRCD   = 2,
  parameter int unsigned TRP    = 2,
  parameter int unsigned TRFC   = 7
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        sd_cke,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [11:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_i,
  output logic [15:0] sd_dq_o,
  output logic        sd_dq_oe,
  output logic [11:0] mode_reg,
  output logic [15:0] refresh_cnt,
  output logic        proto_err
);

  localparam int unsigned NBANK = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned RW    = 12;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_BT  = 3'b110;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LM  = 3'b000;

  typedef enum logic {BANK_IDLE = 1'b0, BANK_ACTIVE = 1'b1} bank_state_e;

  bank_state_e       bank_st_q  [NBANK];
  bank_state_e       bank_st_d  [NBANK];
  logic [RW-1:0]     bank_row_q [NBANK];
  logic [RW-1:0]     bank_row_d [NBANK];
  logic              mode_valid_q, mode_valid_d;
  logic [11:0]       mode_reg_q, mode_reg_d;
  logic [15:0]       refresh_cnt_q, refresh_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic              s0_vld_q, s0_vld_d;
  logic              s0_cl3_q, s0_cl3_d;
  logic [1:0]        s0_dqm_q, s0_dqm_d;
  logic              s1_vld_q, s1_vld_d;
  logic [DW-1:0]     s1_data_q, s1_data_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DW-1:0]     dq_o_q, dq_o_d;

  logic [DW-1:0]     mem [2**MEM_AW];
  logic [DW-1:0]     ram_q;
  logic [MEM_AW-1:0] mem_addr_c;
  logic [DW-1:0]     s0_data_c;
  logic [2:0]        code_c;
  logic              cmd_vld_c;
  logic              all_idle_c;
  logic              rd_en_c, wr_en_c, flush_c, err_c;
  logic              act_ev_c, ref_ev_c;
  logic [NBANK-1:0]  pre_mask_c;
  logic              timing_err_c;

  assign code_c     = {sd_nras, sd_ncas, sd_nwe};
  assign cmd_vld_c  = sd_cke & ~sd_ncs & (code_c != C_NOP);
  assign mem_addr_c = MEM_AW'({sd_ba, bank_row_q[sd_ba], sd_a[7:0]});
  assign s0_data_c  = {s0_dqm_q[1] ? 8'h00 : ram_q[15:8], s0_dqm_q[0] ? 8'h00 : ram_q[7:0]};

  always_comb begin
    all_idle_c = 1'b1;
    for (int i = 0; i < NBANK; i++) begin
      if (bank_st_q[i] != BANK_IDLE) all_idle_c = 1'b0;
    end
  end

  // Command decode, bank FSMs, mode/refresh registers and read pipeline
  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      bank_st_d[i]  = bank_st_q[i];
      bank_row_d[i] = bank_row_q[i];
    end
    mode_valid_d  = mode_valid_q;
    mode_reg_d    = mode_reg_q;
    refresh_cnt_d = refresh_cnt_q;
    proto_err_d   = proto_err_q;
    s0_vld_d      = s0_vld_q;
    s0_cl3_d      = s0_cl3_q;
    s0_dqm_d      = s0_dqm_q;
    s1_vld_d      = s1_vld_q;
    s1_data_d     = s1_data_q;
    dq_oe_d       = dq_oe_q;
    dq_o_d        = dq_o_q;
    rd_en_c       = 1'b0;
    wr_en_c       = 1'b0;
    flush_c       = 1'b0;
    err_c         = 1'b0;
    act_ev_c      = 1'b0;
    ref_ev_c      = 1'b0;
    pre_mask_c    = '0;

    if (cmd_vld_c) begin
      // Refresh belongs to the power-up sequence, so it is accepted before the mode is loaded
      if (!mode_valid_q && !(code_c inside {C_LM, C_PRE, C_REF})) begin
        err_c = 1'b1;
      end else begin
        case (code_c)
          C_ACT: begin
            if (bank_st_q[sd_ba] != BANK_IDLE) begin
              err_c = 1'b1;
            end else begin
              bank_st_d[sd_ba]  = BANK_ACTIVE;
              bank_row_d[sd_ba] = sd_a;
              act_ev_c          = 1'b1;
            end
          end
          C_RD, C_WR: begin
            if (bank_st_q[sd_ba] == BANK_IDLE) begin
              err_c = 1'b1;
            end else begin
              rd_en_c = (code_c == C_RD);
              wr_en_c = (code_c == C_WR);
              flush_c = (code_c == C_WR);
              if (sd_a[10]) pre_mask_c[sd_ba] = 1'b1;
            end
          end
          C_BT: flush_c = 1'b1;
          C_PRE: begin
            if (sd_a[10]) pre_mask_c = '1;
            else          pre_mask_c[sd_ba] = 1'b1;
          end
          C_REF: begin
            if (!all_idle_c) begin
              err_c = 1'b1;
            end else begin
              refresh_cnt_d = refresh_cnt_q + 16'd1;
              ref_ev_c      = 1'b1;
            end
          end
          C_LM: begin
            if (!all_idle_c || !(sd_a[6:4] inside {3'd2, 3'd3}) || (sd_a[2:0] != 3'b000)) begin
              err_c = 1'b1;
            end else begin
              mode_reg_d   = sd_a;
              mode_valid_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (timing_err_c) err_c = 1'b1;
    end

    for (int i = 0; i < NBANK; i++) begin
      if (pre_mask_c[i]) bank_st_d[i] = BANK_IDLE;
    end
    if (err_c) proto_err_d = 1'b1;

    // CL2 words leave from stage 0, CL3 words take one more hop through stage 1
    if (sd_cke) begin
      s0_vld_d  = rd_en_c;
      s0_cl3_d  = (mode_reg_q[6:4] == 3'd3);
      s0_dqm_d  = {sd_dqmh, sd_dqml};
      s1_vld_d  = s0_vld_q & s0_cl3_q;
      s1_data_d = s0_data_c;
      dq_oe_d   = s1_vld_q | (s0_vld_q & ~s0_cl3_q);
      if (s1_vld_q)                  dq_o_d = s1_data_q;
      else if (s0_vld_q & ~s0_cl3_q) dq_o_d = s0_data_c;
      else                           dq_o_d = '0;
      if (flush_c) begin
        s0_vld_d = 1'b0;
        s1_vld_d = 1'b0;
        dq_oe_d  = 1'b0;
        dq_o_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < NBANK; i++) begin
        bank_st_q[i]  <= BANK_IDLE;
        bank_row_q[i] <= '0;
      end
      mode_valid_q  <= 1'b0;
      mode_reg_q    <= '0;
      refresh_cnt_q <= '0;
      proto_err_q   <= 1'b0;
      s0_vld_q      <= 1'b0;
      s0_cl3_q      <= 1'b0;
      s0_dqm_q      <= '0;
      s1_vld_q      <= 1'b0;
      s1_data_q     <= '0;
      dq_oe_q       <= 1'b0;
      dq_o_q        <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        bank_st_q[i]  <= bank_st_d[i];
        bank_row_q[i] <= bank_row_d[i];
      end
      mode_valid_q  <= mode_valid_d;
      mode_reg_q    <= mode_reg_d;
      refresh_cnt_q <= refresh_cnt_d;
      proto_err_q   <= proto_err_d;
      s0_vld_q      <= s0_vld_d;
      s0_cl3_q      <= s0_cl3_d;
      s0_dqm_q      <= s0_dqm_d;
      s1_vld_q      <= s1_vld_d;
      s1_data_q     <= s1_data_d;
      dq_oe_q       <= dq_oe_d;
      dq_o_q        <= dq_o_d;
    end
  end

  // Backing RAM: byte-enabled write port and a registered read port, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      if (!sd_dqml) mem[mem_addr_c][7:0]  <= sd_dq_i[7:0];
      if (!sd_dqmh) mem[mem_addr_c][15:8] <= sd_dq_i[15:8];
    end
    if (rd_en_c) ram_q <= mem[mem_addr_c];
  end

`ifdef SDRAM_TIMING_CHECK_EN
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TRCD_LD = (TRCD > 0) ? TRCD - 1 : 0;
  localparam int unsigned TRP_LD  = (TRP  > 0) ? TRP  - 1 : 0;
  localparam int unsigned TRFC_LD = (TRFC > 0) ? TRFC - 1 : 0;

  logic [CNT_W-1:0] trcd_cnt_q [NBANK];
  logic [CNT_W-1:0] trp_cnt_q  [NBANK];
  logic [CNT_W-1:0] trfc_cnt_q;

  always_comb begin
    timing_err_c = 1'b0;
    if (cmd_vld_c) begin
      if (trfc_cnt_q != '0) timing_err_c = 1'b1;
      if ((code_c == C_ACT) && (trp_cnt_q[sd_ba] != '0)) timing_err_c = 1'b1;
      if ((code_c inside {C_RD, C_WR}) && (trcd_cnt_q[sd_ba] != '0)) timing_err_c = 1'b1;
    end
  end

  // Counters hold the cycles still to wait; a load overrides the countdown
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < NBANK; i++) begin
        trcd_cnt_q[i] <= '0;
        trp_cnt_q[i]  <= '0;
      end
      trfc_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (act_ev_c && (sd_ba == 2'(i)))  trcd_cnt_q[i] <= CNT_W'(TRCD_LD);
        else if (trcd_cnt_q[i] != '0)      trcd_cnt_q[i] <= trcd_cnt_q[i] - CNT_W'(1);
        if (pre_mask_c[i])                 trp_cnt_q[i]  <= CNT_W'(TRP_LD);
        else if (trp_cnt_q[i] != '0)       trp_cnt_q[i]  <= trp_cnt_q[i] - CNT_W'(1);
      end
      if (ref_ev_c)               trfc_cnt_q <= CNT_W'(TRFC_LD);
      else if (trfc_cnt_q != '0)  trfc_cnt_q <= trfc_cnt_q - CNT_W'(1);
    end
  end
`else
  logic unused_timing;
  assign timing_err_c  = 1'b0;
  assign unused_timing = ^{32'(TRCD), 32'(TRP), 32'(TRFC), act_ev_c, ref_ev_c, pre_mask_c};
`endif

  assign sd_dq_o     = dq_o_q;
  assign sd_dq_oe    = dq_oe_q;
  assign mode_reg    = mode_reg_q;
  assign refresh_cnt = refresh_cnt_q;
  assign proto_err   = proto_err_q;

endmodule
